// File: rtl/bus_responder_pkg.sv
// Shared types for the strobe-protocol responder.
// State codes, default widths, direction helper.
package bus_responder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    RD_WAIT   = 4'h1,
    RD_HELD   = 4'h2,
    RD_DRIVE  = 4'h3,
    WR_WAIT   = 4'h4,
    WR_HELD   = 4'h5,
    WR_COMMIT = 4'h6
  } state_t;

  function automatic logic is_rd(state_t s);
    return s inside {RD_WAIT, RD_HELD, RD_DRIVE};
  endfunction

endpackage

// File: rtl/bus_word_mem.sv
// Word array: synchronous write, asynchronous read.
// Ports: clock, we, addr, wdata, rdata.
module bus_word_mem
  import bus_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the six-phase strobe bus.
// Ports: strobes in; data_out/data_oe, addr, write_done, error out.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chipSelect,
  input  logic              readEnable,
  input  logic              outputEnable,
  input  logic              increment,
  input  logic              latch,
  input  logic              dataValid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr,
  output logic              write_done,
  output logic              error
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] rd_reg, rd_n;
  logic [DATA_W-1:0] wr_reg, wr_n;
  logic [DATA_W-1:0] dout_n;
  logic [DATA_W-1:0] rdata;
  logic              oe_n;
  logic              done_n;
  logic              err_n;
  logic              we;

  bus_word_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (we),
    .addr  (addr),
    .wdata (wr_reg),
    .rdata (rdata)
  );

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rd_n    = rd_reg;
    wr_n    = wr_reg;
    dout_n  = data_out;
    oe_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = error;
    we      = 1'b0;
    if (!chipSelect) begin
      // mem reads/writes use addr, i.e. the
      // pre-increment address
      if (increment) addr_n = addr + 1'b1;
      if (state == IDLE) begin
        if (readEnable) begin
          state_n = latch ? RD_HELD : RD_WAIT;
          if (latch) rd_n = rdata;
        end else begin
          state_n = latch ? WR_HELD : WR_WAIT;
          if (latch) wr_n = data_in;
        end
      end else if (readEnable != is_rd(state)) begin
        state_n = readEnable ? RD_WAIT : WR_WAIT;
      end else begin
        unique case (state)
          RD_WAIT: begin
            if (latch) begin
              state_n = RD_HELD;
              rd_n    = rdata;
            end else if (!outputEnable) begin
              // early drive: flag it, put out stale data
              err_n = 1'b1;
              oe_n  = 1'b1;
            end
          end
          RD_HELD: begin
            if (latch) begin
              rd_n = rdata;
            end else if (!outputEnable) begin
              state_n = RD_DRIVE;
              oe_n    = 1'b1;
            end
          end
          RD_DRIVE: begin
            oe_n = !outputEnable;
            if (latch) rd_n = rdata;
            else if (outputEnable) state_n = RD_WAIT;
          end
          WR_WAIT: begin
            if (latch) begin
              state_n = WR_HELD;
              wr_n    = data_in;
            end else if (dataValid) begin
              err_n = 1'b1;
            end
          end
          WR_HELD: begin
            if (latch) begin
              wr_n = data_in;
            end else if (dataValid) begin
              state_n = WR_COMMIT;
              we      = 1'b1;
              done_n  = 1'b1;
            end
          end
          WR_COMMIT: state_n = WR_WAIT;
          default:   state_n = IDLE;
        endcase
      end
    end
    if (oe_n) dout_n = rd_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      rd_reg     <= '0;
      wr_reg     <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      write_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      rd_reg     <= rd_n;
      wr_reg     <= wr_n;
      data_out   <= dout_n;
      data_oe    <= oe_n;
      write_done <= done_n;
      error      <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed + randomized bench for bus_responder.
// Reference: word array, address counter, error flag.
module tb_bus_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       chipSelect = 1'b0;
  logic       readEnable = 1'b0;
  logic       outputEnable = 1'b1;
  logic       increment = 1'b0;
  logic       latch = 1'b0;
  logic       dataValid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic [3:0] addr;
  logic       write_done;
  logic       error;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mdl_mem [16];
  bit         mdl_vld [16];
  int         mdl_addr = 0;
  logic       mdl_err = 1'b0;

  bus_responder dut (
    .clock        (clock),
    .reset        (reset),
    .chipSelect   (chipSelect),
    .readEnable   (readEnable),
    .outputEnable (outputEnable),
    .increment    (increment),
    .latch        (latch),
    .dataValid    (dataValid),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .addr         (addr),
    .write_done   (write_done),
    .error        (error)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h",
                tag, obs, exp);
  endtask

  task automatic do_inc();
    increment = 1'b1;
    tick();
    increment = 1'b0;
    mdl_addr = (mdl_addr + 1) % 16;
    chk("addr_inc", 32'(addr), 32'(mdl_addr));
  endtask

  task automatic goto_addr(input int a);
    for (int i = 0; i < 16 && mdl_addr != a; i++)
      do_inc();
    chk("goto", 32'(addr), 32'(a));
  endtask

  task automatic write_word(input logic [7:0] d);
    readEnable = 1'b0;
    tick();
    data_in = d;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
    mdl_mem[mdl_addr] = d;
    mdl_vld[mdl_addr] = 1'b1;
    chk("wdone_hi", 32'(write_done), 32'd1);
    tick();
    chk("wdone_lo", 32'(write_done), 32'd0);
  endtask

  task automatic read_word();
    readEnable = 1'b1;
    tick();
    latch = 1'b1;
    tick();
    latch = 1'b0;
    outputEnable = 1'b0;
    tick();
    chk("rd_oe", 32'(data_oe), 32'd1);
    chk("rd_data", 32'(data_out),
        32'(mdl_mem[mdl_addr]));
    outputEnable = 1'b1;
    tick();
    chk("rd_oe_off", 32'(data_oe), 32'd0);
    chk("rd_err", 32'(error), 32'(mdl_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl_addr = 0;
    mdl_err = 1'b0;
  endtask

  initial begin
    int a;
    logic [3:0] hold_addr;
    for (int i = 0; i < 16; i++) mdl_vld[i] = 1'b0;

    tick();
    tick();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_oe", 32'(data_oe), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_wdone", 32'(write_done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;

    // write then read
    do_inc();
    write_word(8'hA5);
    read_word();
    chk("wr_rd_addr", 32'(addr), 32'd1);

    // wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_inc();
    chk("wrap0", 32'(addr), 32'd0);
    goto_addr(15);
    write_word(8'h3C);
    do_inc();
    chk("wrap1", 32'(addr), 32'd0);
    goto_addr(15);
    read_word();

    // randomized writes and reads
    for (int i = 0; i < 12; i++) begin
      goto_addr(int'($urandom_range(15)));
      write_word(8'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(15));
      if (mdl_vld[a]) begin
        goto_addr(a);
        read_word();
      end
    end

    // increment and latch together
    goto_addr(2);
    write_word(8'h11);
    goto_addr(3);
    write_word(8'h22);
    goto_addr(2);
    readEnable = 1'b1;
    tick();
    increment = 1'b1;
    latch = 1'b1;
    tick();
    increment = 1'b0;
    latch = 1'b0;
    mdl_addr = 3;
    chk("inclat_addr", 32'(addr), 32'd3);
    outputEnable = 1'b0;
    tick();
    chk("inclat_data", 32'(data_out), 32'h11);
    outputEnable = 1'b1;
    tick();

    // deselect with a write held
    readEnable = 1'b0;
    tick();
    data_in = 8'hEE;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    hold_addr = addr;
    chipSelect = 1'b1;
    for (int i = 0; i < 10; i++) begin
      increment = 1'($urandom);
      latch = 1'($urandom);
      dataValid = 1'($urandom);
      outputEnable = 1'($urandom);
      readEnable = 1'($urandom);
      tick();
      chk("desel_addr", 32'(addr), 32'(hold_addr));
      chk("desel_oe", 32'(data_oe), 32'd0);
      chk("desel_err", 32'(error), 32'd0);
      chk("desel_wd", 32'(write_done), 32'd0);
    end
    chipSelect = 1'b0;
    {increment, latch, dataValid} = 3'b000;
    outputEnable = 1'b1;
    readEnable = 1'b0;
    read_word();

    // dataValid with nothing latched
    readEnable = 1'b0;
    tick();
    data_in = 8'h99;
    dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
    mdl_err = 1'b1;
    chk("dv_err", 32'(error), 32'd1);
    chk("dv_nowd", 32'(write_done), 32'd0);
    read_word();

    // early outputEnable
    do_reset();
    readEnable = 1'b1;
    tick();
    outputEnable = 1'b0;
    tick();
    mdl_err = 1'b1;
    chk("oe_err", 32'(error), 32'd1);
    chk("oe_stale_oe", 32'(data_oe), 32'd1);
    chk("oe_stale_d", 32'(data_out), 32'd0);
    outputEnable = 1'b1;
    tick();
    chk("oe_drop", 32'(data_oe), 32'd0);
    goto_addr(3);
    read_word();

    // reset during WR_HELD
    do_reset();
    goto_addr(5);
    write_word(8'h5A);
    data_in = 8'hFF;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_addr", 32'(addr), 32'd0);
    chk("mid_oe", 32'(data_oe), 32'd0);
    chk("mid_dout", 32'(data_out), 32'd0);
    chk("mid_wd", 32'(write_done), 32'd0);
    chk("mid_err", 32'(error), 32'd0);
    dataValid = 1'b1;
    tick();
    chk("mid_wd2", 32'(write_done), 32'd0);
    reset = 1'b0;
    mdl_addr = 0;
    mdl_err = 1'b0;
    tick();
    dataValid = 1'b0;
    chk("mid_wd3", 32'(write_done), 32'd0);
    tick();
    chk("mid_wd4", 32'(write_done), 32'd0);
    goto_addr(5);
    read_word();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the six-phase read/write strobe protocol issued by the lab bus controller. Tracks a word address, captures the addressed word on `latch` and drives it while `outputEnable` is low during reads. During writes it captures `data_in` on `latch` and commits it to an internal word array on a `dataValid` pulse. Sits between the controller's strobe outputs and the shared data bus, standing in for the external SRAM in lab builds and benches.

## Interface

- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 4: address width; depth is 2^ADDR_W words.
- `clock`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `chipSelect`, in, 1: active-low select; high means all strobes are ignored.
- `readEnable`, in, 1: 1 = read direction, 0 = write direction.
- `outputEnable`, in, 1: active-low read drive request.
- `increment`, in, 1: one-cycle address advance strobe.
- `latch`, in, 1: one-cycle capture strobe.
- `dataValid`, in, 1: write commit strobe; ignored in read direction.
- `data_in`, in, DATA_W: write data from the controller side.
- `data_out`, out, DATA_W: read data.
- `data_oe`, out, 1: bus drive enable for `data_out`.
- `addr`, out, ADDR_W: current word address.
- `write_done`, out, 1: one-cycle pulse after each commit.
- `error`, out, 1: sticky protocol-violation flag.

## Operation

- All inputs are sampled on the rising `clock` edge. All outputs are registered.
- **Selection:** when `chipSelect`=1, no state change occurs, `data_oe`=0, and no strobe has any effect.
- **Address:** `increment`=1 sets `addr` to `addr`+1 modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
  - Any capture or commit in the same cycle as an increment uses the pre-increment address.
- **Direction:** a `readEnable` value differing from the current state's direction forces RD_WAIT or WR_WAIT in that cycle. Other strobes in that cycle are ignored, except `increment`.
- **Read FSM:**
  - RD_WAIT —`latch`→ RD_HELD, with `rd_reg` ← mem[addr].
  - RD_HELD —`outputEnable`=0→ RD_DRIVE.
  - RD_DRIVE —`outputEnable`=1→ RD_WAIT.
  - `latch` in RD_HELD or RD_DRIVE re-captures and stays in the current state.
  - `outputEnable`=0 in RD_WAIT sets `error`, and the block drives stale `rd_reg` for that low period.
- **Write FSM:**
  - WR_WAIT —`latch`→ WR_HELD, with `wr_reg` ← `data_in`.
  - WR_HELD —`dataValid`=1→ WR_COMMIT, with mem[addr] ← `wr_reg`.
  - WR_COMMIT → WR_WAIT unconditionally.
  - `latch` in WR_HELD re-captures `wr_reg`.
  - `dataValid`=1 in WR_WAIT sets `error` and does not write.
  - `dataValid`=1 in WR_COMMIT is ignored.
- **Idle:** IDLE exits to RD_WAIT or WR_WAIT on the first selected cycle, chosen by `readEnable`. `latch` in that cycle is already honoured per the new state.
- `error` is cleared only by `reset`.

## Timing

- **Reset values:** state IDLE, `addr`=0, `rd_reg`=0, `wr_reg`=0, `data_out`=0, `data_oe`=0, `write_done`=0, `error`=0.
  - The memory array is not reset.
- Reset asserted mid-operation returns everything to these values immediately. Any in-flight commit is dropped.
- `addr` updates the cycle after `increment` is sampled.
- `data_oe`=1 and `data_out`=`rd_reg` starting the cycle after `outputEnable`=0 is sampled in RD_HELD or RD_WAIT.
- `data_oe` drops the cycle after `outputEnable`=1, direction change, or `chipSelect`=1 is sampled.
- A memory write takes effect at the edge sampling `dataValid`. `write_done`=1 for exactly the following cycle.
- Read-after-write to the same address: a `latch` one cycle after the commit edge returns the new data.

## Structure

- **Shared package:** state encoding (IDLE, RD_WAIT, RD_HELD, RD_DRIVE, WR_WAIT, WR_HELD, WR_COMMIT) as 4-bit constants alongside the controller's, plus default DATA_W/ADDR_W.
- **Sub-module:** one, `bus_word_mem`, a single-port synchronous-write, asynchronous-read array parameterised by DATA_W and ADDR_W.
- The FSM, address counter and registers stay in `bus_responder`.

## Test plan

- **Write then read:** write sequence with `data_in`=8'hA5 (increment, latch, dataValid pulse), then read sequence → `addr`=1 after each increment, `write_done` pulse once, `data_out`=8'hA5 with `data_oe`=1 during `outputEnable` low, `error`=0.
- **Wrap:** 16 increments from reset with ADDR_W=4 → `addr` sequence 1…15, 0. Write 8'h3C at address 15 and read it back after the wrap → 8'h3C.
- **Deselect:** `chipSelect`=1 with `increment`, `latch` and `dataValid` toggling → `addr`, memory and `error` unchanged, `data_oe`=0.
- **Protocol errors:**
  - `outputEnable`=0 in RD_WAIT → `error`=1, stays 1 after later legal cycles.
  - Separately, `dataValid` in WR_WAIT → `error`=1 and memory unchanged.
- **Simultaneous increment and latch:** mem[2]=8'h11, mem[3]=8'h22 at `addr`=2; `increment` and `latch` in the same cycle → `rd_reg`=8'h11, `addr`=3.
- **Reset mid-operation:** assert `reset` during WR_HELD holding 8'hFF → all outputs at reset values immediately, no commit to memory, `write_done` never pulses.
